// File: rtl/song_recorder.sv
// song_recorder: captures key press/release timing as {note,duration} entries into song RAM
module song_recorder #(
  parameter int ADDR_W  = 5,
  parameter int MAX_DUR = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                record_button,
  input  logic [1:0]          song,
  input  logic                key_down,
  input  logic                key_up,
  input  logic [5:0]          key_note,
  input  logic                beat,
  output logic                wr_en,
  output logic [ADDR_W+1:0]   wr_addr,
  output logic [11:0]         wr_data,
  output logic                recording,
  output logic                rec_done
);
  typedef enum logic [2:0] {IDLE, ARMED, HOLD, REST, STOP_CLOSE, STOP_MARK} state_t;
  localparam logic [5:0] MAXD = 6'(MAX_DUR);
  localparam logic [ADDR_W-1:0] LAST_DATA = {{(ADDR_W-1){1'b1}}, 1'b0};
  state_t              state_q, state_d;
  logic [1:0]          song_q, song_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [5:0]          dur_q, dur_d, note_q, note_d, cnt;
  logic                wr_en_q, wr_en_d, rec_done_q, rec_done_d;
  logic [ADDR_W+1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d, wdata;
  logic                we, marker, kd, close;
  assign kd = key_down && (key_note != 6'd0);
  assign cnt = (beat && dur_q != MAXD) ? dur_q + 6'd1 : dur_q;
  assign close = kd || (key_up && state_q == HOLD);
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rec_done = rec_done_q;
  assign recording = state_q != IDLE;
  // Next-state: a beat is counted before any same-cycle close; note_q is zero while resting
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    index_d = index_q;
    dur_d   = dur_q;
    note_d  = note_q;
    we      = 1'b0;
    marker  = 1'b0;
    wdata   = {note_q, dur_q};
    case (state_q)
      IDLE: if (record_button) begin
        song_d  = song;
        index_d = '0;
        dur_d   = '0;
        state_d = ARMED;
      end
      ARMED: if (record_button) state_d = STOP_CLOSE;
      else if (kd) begin
        note_d  = key_note;
        dur_d   = '0;
        state_d = HOLD;
      end
      HOLD, REST: if (record_button) begin
        dur_d   = cnt;
        state_d = STOP_CLOSE;
      end else if (close) begin
        we      = cnt != 6'd0;
        wdata   = {note_q, cnt};
        dur_d   = '0;
        note_d  = kd ? key_note : 6'd0;
        state_d = kd ? HOLD : REST;
      end else if (beat && dur_q == MAXD) begin
        we    = 1'b1;
        wdata = {note_q, MAXD};
        dur_d = 6'd1;
      end else dur_d = cnt;
      STOP_CLOSE: begin
        we      = dur_q != 6'd0;
        state_d = STOP_MARK;
      end
      STOP_MARK: begin
        we      = 1'b1;
        marker  = 1'b1;
        wdata   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (we && !marker) index_d = index_q + 1'b1;
    if (we && index_q == LAST_DATA && (state_q == HOLD || state_q == REST)) state_d = STOP_MARK;
    wr_en_d    = we;
    wr_addr_d  = we ? {song_q, index_q} : '0;
    wr_data_d  = we ? wdata : '0;
    rec_done_d = marker;
  end
  // State and registered write port, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      song_q     <= '0;
      index_q    <= '0;
      dur_q      <= '0;
      note_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rec_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      index_q    <= index_d;
      dur_q      <= dur_d;
      note_q     <= note_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rec_done_q <= rec_done_d;
    end
  end
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed vectors against hand-computed song RAM writes
module tb_song_recorder;
  logic clk = 0, reset = 1, record_button = 0, key_down = 0, key_up = 0, beat = 0;
  logic [1:0] song = 0;
  logic [5:0] key_note = 0;
  logic wr_en, recording, rec_done;
  logic [6:0] wr_addr;
  logic [11:0] wr_data;
  logic [6:0] la [256];
  logic [11:0] ld [256];
  logic lr [256];
  int nw = 0, n_cmp = 0, n_bad = 0, base;
  song_recorder dut (.clk(clk), .reset(reset), .record_button(record_button), .song(song),
    .key_down(key_down), .key_up(key_up), .key_note(key_note), .beat(beat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .recording(recording), .rec_done(rec_done));
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en && nw < 256) begin
    la[nw] = wr_addr;
    ld[nw] = wr_data;
    lr[nw] = rec_done;
    nw = nw + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rb, input logic kd, input logic ku, input logic bt, input logic [5:0] n);
    @(negedge clk);
    record_button = rb; key_down = kd; key_up = ku; beat = bt; key_note = n;
    @(posedge clk);
    #1;
    record_button = 0; key_down = 0; key_up = 0; beat = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask
  task automatic beats(input int n);
    repeat (n) cyc(0, 0, 0, 1, 0);
  endtask
  task automatic wr(input string tag, input int k, input logic [6:0] a, input logic [11:0] d, input logic r);
    chk({tag, " addr"}, la[(base + k) % 256], a);
    chk({tag, " data"}, ld[(base + k) % 256], d);
    chk({tag, " done"}, lr[(base + k) % 256], r);
  endtask
  initial begin
    #1;
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst recording", recording, 0);
    chk("rst rec_done", rec_done, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    idle(2);
    // basic note, rest, stop on song 2
    base = nw;
    song = 2;
    cyc(1, 0, 0, 0, 0);
    song = 0;
    chk("t1 recording", recording, 1);
    cyc(0, 1, 0, 0, 20);
    beats(3);
    cyc(0, 0, 1, 0, 0);
    beats(2);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("t1 count", nw - base, 3);
    wr("t1 e0", 0, 7'h40, 12'd1283, 0);
    wr("t1 e1", 1, 7'h41, 12'd2, 0);
    wr("t1 mk", 2, 7'h42, 12'd0, 1);
    chk("t1 recording end", recording, 0);
    // saturation over 70 beats
    base = nw;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 5);
    beats(63);
    chk("t2 no write at 63", nw - base, 0);
    beats(7);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("t2 count", nw - base, 3);
    wr("t2 e0", 0, 7'h00, 12'd383, 0);
    wr("t2 e1", 1, 7'h01, 12'd327, 0);
    wr("t2 mk", 2, 7'h02, 12'd0, 1);
    // legato with coincident beat
    base = nw;
    song = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 9);
    beats(2);
    cyc(0, 1, 0, 1, 11);
    beats(1);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("t3 count", nw - base, 3);
    wr("t3 e0", 0, 7'h20, 12'd579, 0);
    wr("t3 e1", 1, 7'h21, 12'd705, 0);
    wr("t3 mk", 2, 7'h22, 12'd0, 1);
    // zero-duration note suppressed
    base = nw;
    song = 3;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 7);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("t4 count", nw - base, 1);
    wr("t4 mk", 0, 7'h60, 12'd0, 1);
    // fill song 0 and auto-stop
    base = nw;
    song = 0;
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 1, 0, 0, 6'(i));
      beats(1);
    end
    cyc(0, 0, 1, 0, 0);
    beats(1);
    cyc(0, 1, 0, 0, 33);
    idle(4);
    chk("t5 count", nw - base, 32);
    wr("t5 e0", 0, 7'h00, 12'd65, 0);
    wr("t5 e29", 29, 7'h1d, 12'd1921, 0);
    wr("t5 e30", 30, 7'h1e, 12'd1, 0);
    wr("t5 mk", 31, 7'h1f, 12'd0, 1);
    chk("t5 recording end", recording, 0);
    // asynchronous reset while holding
    base = nw;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 4);
    beats(2);
    cyc(0, 1, 0, 0, 6);
    chk("t6 wr_en before", wr_en, 1);
    #2 reset = 1;
    #1;
    chk("t6 wr_en", wr_en, 0);
    chk("t6 wr_addr", wr_addr, 0);
    chk("t6 wr_data", wr_data, 0);
    chk("t6 recording", recording, 0);
    chk("t6 rec_done", rec_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    beats(2);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    chk("t6 no write", nw - base, 0);
    chk("t6 idle", recording, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: log2 of the number of entries per song (32).
REQ-002 SHALL have parameter MAX_DUR, default 63: the saturating beat count per entry, at most 63.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port record_button, input, 1 bit: debounced one-pulse that starts or stops recording.
REQ-006 SHALL have port song, input, 2 bits: the target song slot, latched at record start.
REQ-007 SHALL have port key_down, input, 1 bit: one-cycle pulse for a key press.
REQ-008 SHALL have port key_up, input, 1 bit: one-cycle pulse for a key release.
REQ-009 SHALL have port key_note, input, 6 bits: note code, valid with key_down; value 0 is illegal as a played note.
REQ-010 SHALL have port beat, input, 1 bit: one-cycle beat tick from beat_generator.
REQ-011 SHALL have port wr_en, output, 1 bit: one-cycle song-RAM write strobe.
REQ-012 SHALL have port wr_addr, output, 2+ADDR_W bits: {song_latched, index}.
REQ-013 SHALL have port wr_data, output, 12 bits: {note[11:6], duration[5:0]}, the entry format song_reader consumes.
REQ-014 SHALL have port recording, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port rec_done, output, 1 bit: one-cycle pulse when the end marker is written.

Function
REQ-016 SHALL implement states IDLE, ARMED, HOLD, REST, STOP_CLOSE and STOP_MARK.
REQ-017 SHALL, in IDLE on record_button: latch song, clear index and dur_cnt, and go to ARMED; no write occurs.
REQ-018 SHALL, in ARMED on key_down: latch key_note, clear dur_cnt, and go to HOLD; beats in ARMED are not counted (no leading rest).
REQ-019 SHALL, in HOLD or REST, increment dur_cnt on each beat, saturating at MAX_DUR.
REQ-020 SHALL, when a beat would take dur_cnt past MAX_DUR: write the entry with duration MAX_DUR, set dur_cnt to 1, and stay in the same state.
REQ-021 SHALL, on key_up in HOLD: write {note, dur_cnt}, clear dur_cnt, and go to REST.
REQ-022 SHALL, on key_down in HOLD (legato): write {old note, dur_cnt}, latch the new note, clear dur_cnt, and stay in HOLD.
REQ-023 SHALL, on key_down in REST: write {0, dur_cnt}, latch the note, clear dur_cnt, and go to HOLD.
REQ-024 SHALL suppress any entry whose duration is 0 at close: no write, and index unchanged.
REQ-025 SHALL ignore key_up in ARMED and REST, and ignore key_down in STOP_* states.
REQ-026 SHALL, when beat coincides with key_up or key_down, count the beat first and then close the entry.
REQ-027 SHALL register wr_en, wr_addr and wr_data, so the write occurs exactly one cycle after the triggering event.
REQ-028 SHALL increment index by 1 after each write, and never wrap.
REQ-029 SHALL reserve the last slot (index 2^ADDR_W-1) for the end marker.
REQ-030 SHALL, when a write lands at index 2^ADDR_W-2, enter STOP_MARK immediately after it (auto-stop).
REQ-031 SHALL, on record_button in ARMED, HOLD or REST, go to STOP_CLOSE.
REQ-032 SHALL, in STOP_CLOSE, write the open entry (note, or 0 for a rest) if dur_cnt>0, then enter STOP_MARK on the next cycle.
REQ-033 SHALL, in STOP_MARK, write the end marker {0,0} at the current index, pulse rec_done in the same cycle as that wr_en, and return to IDLE.
REQ-034 SHALL make record_button in STOP_* states a no-op.
REQ-035 SHALL give record_button priority over key events in the same cycle.
REQ-036 SHALL never issue more than one write per cycle; the worst case is stop from HOLD, with two writes on consecutive cycles.

Reset
REQ-037 SHALL, while reset is high, asynchronously force state IDLE, index 0 and dur_cnt 0.
REQ-038 SHALL, while reset is high, drive wr_en 0, wr_addr 0, wr_data 0, recording 0 and rec_done 0.
REQ-039 SHALL, on reset mid-recording, abandon the recording without writing an end marker; earlier RAM writes remain.

Verification
REQ-040 SHALL cover: song=2, record; key_down note 20; 3 beats; key_up; 2 beats; record -> writes (0x40,{20,3}), (0x41,{0,2}), (0x42,{0,0}); rec_done is high with the third wr_en; recording falls.
REQ-041 SHALL cover: hold note 5 for 70 beats, then key_up -> writes {5,63} on beat 64, then {5,7} on key_up.
REQ-042 SHALL cover: key_down 9, 2 beats, key_down 11 with a beat in the same cycle -> write {9,3}, then HOLD on note 11 with dur_cnt 0.
REQ-043 SHALL cover: key_down, then key_up before any beat -> no write; index stays 0.
REQ-044 SHALL cover: 30 one-beat notes on song 0 -> writes at index 0..30 (the write at index 30 ends in a rest entry {0,1} here), then the end marker at index 31 with no record_button press.
REQ-045 SHALL cover: reset asserted while in HOLD -> all outputs 0 immediately (asynchronous); no write on the next clock.
